dl_meas_sequencer: RTL and testbench

Measurement sequencer for the delay-line platform. On each trigger it fires one `tdc_pulse` into the delay line and counts `clk10m` cycles until the external `tdc_stop` rising edge (with timeout). It then streams a 6-byte result frame through the existing `uart_tx` byte handshake. It sits between the slow-tick divider (drives `trig`) and `uart_tx`, replacing the fixed 0xAA beacon.

---
 rtl/dl_meas_sequencer.sv | 151 +++++++++++++++
 tb/tb_dl_meas_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dl_meas_sequencer.sv
// Measurement sequencer: one TDC launch pulse per trigger, stop-edge timing in
// clk10m cycles with timeout, then a 6-byte result frame over the uart_tx handshake.
module dl_meas_sequencer #(
  parameter int          PULSE_W   = 4,
  parameter logic [15:0] TIMEOUT   = 16'hFFFF,
  parameter logic [7:0]  SYNC_BYTE = 8'hAA
) (
  input  logic        clk10m,
  input  logic        rst_n,
  input  logic        trig,
  input  logic        tdc_stop,
  output logic        tdc_pulse,
  output logic        tx_dv,
  output logic [7:0]  tx_byte,
  input  logic        tx_active,
  input  logic        tx_done,
  output logic        busy,
  output logic [15:0] meas_count,
  output logic        meas_valid
);

  localparam logic [7:0] PW = 8'(PULSE_W);

  typedef enum logic [1:0] {S_IDLE, S_MEAS, S_LOAD, S_WAIT_DONE} state_t;

  state_t      r_state, w_next;
  logic        r_s1, r_s2, r_s3;
  logic [15:0] r_cnt;
  logic [7:0]  r_pulse_left;
  logic        r_first, r_captured, r_timeout, r_overrun;
  logic [7:0]  r_seq, r_csum;
  logic [2:0]  r_idx;
  logic        r_tdc_pulse, r_tx_dv, r_busy, r_meas_valid;
  logic [7:0]  r_tx_byte;
  logic [15:0] r_meas_count;

  logic        w_accept, w_drop, w_stop_edge, w_cap_stop, w_cap_to, w_load;
  logic [2:0]  w_load_idx;
  logic [7:0]  w_byte;

  assign w_accept    = (r_state == S_IDLE) && trig && !tx_active;
  assign w_drop      = trig && !w_accept;
  assign w_stop_edge = r_s2 & ~r_s3;
  assign w_cap_stop  = (r_state == S_MEAS) && !r_captured && w_stop_edge;
  assign w_cap_to    = (r_state == S_MEAS) && !r_captured && !w_stop_edge && (r_cnt == TIMEOUT);
  assign w_load      = (w_next == S_LOAD);
  assign w_load_idx  = (r_state == S_MEAS) ? 3'd0 : r_idx + 3'd1;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_accept) w_next = S_MEAS;
      S_MEAS:      if (r_captured && (r_pulse_left == 8'd0)) w_next = S_LOAD;
      S_LOAD:      w_next = S_WAIT_DONE;
      S_WAIT_DONE: if (tx_done) w_next = (r_idx == 3'd5) ? S_IDLE : S_LOAD;
      default:     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_byte = 8'h00;
    case (w_load_idx)
      3'd0:    w_byte = SYNC_BYTE;
      3'd1:    w_byte = r_seq;
      3'd2:    w_byte = r_meas_count[15:8];
      3'd3:    w_byte = r_meas_count[7:0];
      3'd4:    w_byte = {6'b0, r_overrun, r_timeout};
      3'd5:    w_byte = r_csum;
      default: w_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk10m) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_s1         <= 1'b0;
      r_s2         <= 1'b0;
      r_s3         <= 1'b0;
      r_cnt        <= 16'h0000;
      r_pulse_left <= 8'd0;
      r_first      <= 1'b0;
      r_captured   <= 1'b0;
      r_timeout    <= 1'b0;
      r_overrun    <= 1'b0;
      r_seq        <= 8'h00;
      r_csum       <= 8'h00;
      r_idx        <= 3'd0;
      r_tdc_pulse  <= 1'b0;
      r_tx_dv      <= 1'b0;
      r_tx_byte    <= 8'h00;
      r_busy       <= 1'b0;
      r_meas_count <= 16'h0000;
      r_meas_valid <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_s1         <= tdc_stop;
      r_s2         <= r_s1;
      r_s3         <= r_s2;
      r_busy       <= (w_next != S_IDLE);
      r_tdc_pulse  <= 1'b0;
      r_tx_dv      <= 1'b0;
      r_meas_valid <= 1'b0;

      if (w_accept) begin
        r_cnt        <= 16'h0000;
        r_pulse_left <= PW;
        r_first      <= 1'b1;
        r_captured   <= 1'b0;
      end

      // Counting starts at the launch edge, so the first MEAS cycle holds cnt at 0.
      if (r_state == S_MEAS) begin
        if (r_first) r_first <= 1'b0;
        else         r_cnt   <= r_cnt + 16'd1;
        if (r_pulse_left != 8'd0) begin
          r_tdc_pulse  <= 1'b1;
          r_pulse_left <= r_pulse_left - 8'd1;
        end
        if (w_cap_stop || w_cap_to) begin
          r_captured   <= 1'b1;
          r_meas_valid <= 1'b1;
          r_meas_count <= w_cap_stop ? r_cnt : TIMEOUT;
          r_timeout    <= !w_cap_stop;
        end
      end

      if (w_load) begin
        r_tx_dv   <= 1'b1;
        r_tx_byte <= w_byte;
        r_idx     <= w_load_idx;
        if (w_load_idx == 3'd1)                           r_csum <= w_byte;
        else if (w_load_idx >= 3'd2 && w_load_idx <= 3'd4) r_csum <= r_csum ^ w_byte;
      end

      if ((r_state == S_WAIT_DONE) && tx_done && (r_idx == 3'd5))
        r_seq <= r_seq + 8'd1;

      // A dropped trigger in the byte-4 load cycle still leaves overrun set.
      if (w_drop)                        r_overrun <= 1'b1;
      else if (w_load && w_load_idx == 3'd4) r_overrun <= 1'b0;
    end
  end

  assign tdc_pulse  = r_tdc_pulse;
  assign tx_dv      = r_tx_dv;
  assign tx_byte    = r_tx_byte;
  assign busy       = r_busy;
  assign meas_count = r_meas_count;
  assign meas_valid = r_meas_valid;

endmodule

// File: tb/tb_dl_meas_sequencer.sv
// Directed bench for dl_meas_sequencer with a behavioural uart_tx handshake model.
module tb_dl_meas_sequencer;

  logic        clk10m = 1'b0;
  logic        rst_n = 1'b0, trig = 1'b0, tdc_stop = 1'b0;
  logic        tx_active = 1'b0, tx_done = 1'b0;
  logic        tdc_pulse, tx_dv, busy, meas_valid;
  logic [7:0]  tx_byte;
  logic [15:0] meas_count;

  int vectors = 0, miscompares = 0;
  int cyc = 0;

  always #50 clk10m = ~clk10m;
  always @(posedge clk10m) cyc <= cyc + 1;

  dl_meas_sequencer #(.PULSE_W(4), .TIMEOUT(16'd50), .SYNC_BYTE(8'hAA)) u_dut (
    .clk10m(clk10m), .rst_n(rst_n), .trig(trig), .tdc_stop(tdc_stop),
    .tdc_pulse(tdc_pulse), .tx_dv(tx_dv), .tx_byte(tx_byte),
    .tx_active(tx_active), .tx_done(tx_done), .busy(busy),
    .meas_count(meas_count), .meas_valid(meas_valid)
  );

  int          uart_len = 2, u_left = 0;
  bit          u_extend = 1'b0;
  logic [7:0]  bytes[$];
  int          dv_cnt = 0, dv_first = -1, dv_active_total = 0;
  int          mv_cnt = 0, mv_cyc = -1, pulse_hi = 0, pulse_rise = -1;
  logic [15:0] mv_val = 16'h0;
  logic        prev_pulse = 1'b0;

  // Monitor first, then the uart_tx model, all on the falling edge.
  always @(negedge clk10m) begin
    if (tx_dv === 1'b1) begin
      bytes.push_back(tx_byte);
      if (dv_cnt == 0) dv_first = cyc;
      dv_cnt++;
      if (tx_active) dv_active_total++;
    end
    if (meas_valid === 1'b1) begin
      mv_cnt++;
      mv_cyc = cyc;
      mv_val = meas_count;
    end
    if (tdc_pulse === 1'b1) begin
      pulse_hi++;
      if (prev_pulse !== 1'b1) pulse_rise = cyc;
    end
    prev_pulse = tdc_pulse;
    tx_done = 1'b0;
    if (u_extend) begin
      u_extend  = 1'b0;
      tx_active = 1'b1;
      u_left    = 200;
    end else if (tx_dv === 1'b1) begin
      tx_active = 1'b1;
      u_left    = uart_len;
    end else if (u_left > 0) begin
      u_left--;
      if (u_left == 0) begin
        tx_done   = 1'b1;
        tx_active = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    bytes.delete();
    dv_cnt = 0; dv_first = -1; mv_cnt = 0; mv_cyc = -1;
    pulse_hi = 0; pulse_rise = -1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk10m);
    rst_n = 1'b1;
  endtask

  // Trigger sampled at edge t; tdc_stop first sampled high at edge t+stop_at (0: untouched).
  task automatic measure(input int stop_at, output int t);
    trig = 1'b1;
    t = cyc + 1;
    @(negedge clk10m);
    trig = 1'b0;
    if (stop_at > 0) begin
      repeat (stop_at - 1) @(negedge clk10m);
      tdc_stop = 1'b1;
    end
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 200 && mv_cnt == 0; i++) @(negedge clk10m);
    chk($sformatf("%s_valid_cnt", tag), mv_cnt, 1);
  endtask

  task automatic wait_frame(input string tag, input logic [7:0] e1, input logic [7:0] e2,
                            input logic [7:0] e3, input logic [7:0] e4);
    logic [7:0] e[6];
    e[0] = 8'hAA; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4; e[5] = e1 ^ e2 ^ e3 ^ e4;
    for (int i = 0; i < 20000 && bytes.size() < 6; i++) @(negedge clk10m);
    chk($sformatf("%s_frame_len", tag), (bytes.size() >= 6), 1);
    if (bytes.size() >= 6)
      for (int i = 0; i < 6; i++) chk($sformatf("%s_b%0d", tag, i), bytes.pop_front(), e[i]);
    for (int i = 0; i < 20000 && busy !== 1'b0; i++) @(negedge clk10m);
    chk($sformatf("%s_busy_end", tag), busy, 0);
  endtask

  initial begin
    int t;
    #20ms;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [7:0] sq;

    // Reset held three edges with trig high and tdc_stop toggling.
    trig = 1'b1;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk10m);
      tdc_stop = ~tdc_stop;
      chk($sformatf("rst%0d_pulse", i), tdc_pulse, 0);
      chk($sformatf("rst%0d_dv", i), tx_dv, 0);
      chk($sformatf("rst%0d_byte", i), tx_byte, 8'h00);
      chk($sformatf("rst%0d_busy", i), busy, 0);
      chk($sformatf("rst%0d_count", i), meas_count, 16'h0000);
      chk($sformatf("rst%0d_valid", i), meas_valid, 0);
    end
    trig = 1'b0; tdc_stop = 1'b0; rst_n = 1'b1;
    repeat (4) @(negedge clk10m);
    chk("rst_no_dv", dv_cnt, 0);
    chk("rst_idle", busy, 0);

    // Normal measurement at 10 MHz / 115200 byte timing.
    uart_len = 868;
    clear_mon();
    measure(10, t);
    wait_valid("norm");
    chk("norm_valid_edge", mv_cyc, t + 12);
    chk("norm_count", mv_val, 16'h000A);
    chk("norm_pulse_rise", pulse_rise, t + 1);
    chk("norm_pulse_width", pulse_hi, 4);
    tdc_stop = 1'b0;
    for (int i = 0; i < 20 && dv_cnt == 0; i++) @(negedge clk10m);
    chk("norm_first_dv", dv_first, t + 13);
    wait_frame("norm", 8'h00, 8'h00, 8'h0A, 8'h00);
    chk("norm_one_meas", mv_cnt, 1);

    // Timeout, stop edge coinciding with cnt==TIMEOUT, and stop already high.
    do_reset();
    uart_len = 4;
    clear_mon();
    measure(0, t);
    wait_valid("to");
    chk("to_valid_edge", mv_cyc, t + 52);
    chk("to_count", mv_val, 16'h0032);
    wait_frame("to", 8'h00, 8'h00, 8'h32, 8'h01);
    clear_mon();
    measure(50, t);
    wait_valid("coinc");
    chk("coinc_valid_edge", mv_cyc, t + 52);
    chk("coinc_count", mv_val, 16'h0032);
    wait_frame("coinc", 8'h01, 8'h00, 8'h32, 8'h00);
    clear_mon();
    measure(0, t);
    wait_valid("stophigh");
    chk("stophigh_valid_edge", mv_cyc, t + 52);
    wait_frame("stophigh", 8'h02, 8'h00, 8'h32, 8'h01);
    tdc_stop = 1'b0;

    // Overrun: drops during byte 2 and byte 5 of frame 0.
    do_reset();
    uart_len = 8;
    clear_mon();
    measure(5, t);
    for (int i = 0; i < 2000 && bytes.size() < 3; i++) @(negedge clk10m);
    trig = 1'b1;
    @(negedge clk10m);
    trig = 1'b0;
    chk("ovr_busy_byte2", busy, 1);
    for (int i = 0; i < 2000 && bytes.size() < 6; i++) @(negedge clk10m);
    trig = 1'b1;
    @(negedge clk10m);
    trig = 1'b0;
    wait_frame("ovr0", 8'h00, 8'h00, 8'h05, 8'h02);
    chk("ovr_no_new_meas", mv_cnt, 1);
    chk("ovr_count", mv_val, 16'h0005);
    tdc_stop = 1'b0;
    clear_mon();
    measure(5, t);
    wait_frame("ovr1", 8'h01, 8'h00, 8'h05, 8'h02);
    tdc_stop = 1'b0;
    clear_mon();
    measure(5, t);
    wait_frame("ovr2", 8'h02, 8'h00, 8'h05, 8'h00);
    tdc_stop = 1'b0;

    // Sequence wrap over 257 back-to-back frames.
    do_reset();
    uart_len = 2;
    for (int k = 0; k < 257; k++) begin
      sq = k[7:0];
      clear_mon();
      measure(5, t);
      wait_frame($sformatf("wrap%0d", k), sq, 8'h00, 8'h05, 8'h00);
      tdc_stop = 1'b0;
    end

    // Reset during byte 3 while uart_tx stays active; stale tx_done must be ignored.
    uart_len = 20;
    clear_mon();
    measure(5, t);
    for (int i = 0; i < 2000 && bytes.size() < 4; i++) @(negedge clk10m);
    tdc_stop = 1'b0;
    u_extend = 1'b1;
    rst_n = 1'b0;
    @(negedge clk10m);
    rst_n = 1'b1;
    clear_mon();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_count", meas_count, 16'h0000);
    trig = 1'b1;
    @(negedge clk10m);
    trig = 1'b0;
    chk("mid_trig_dropped", busy, 0);
    for (int i = 0; i < 400 && tx_active === 1'b1; i++) @(negedge clk10m);
    chk("mid_active_released", tx_active, 0);
    repeat (3) @(negedge clk10m);
    chk("mid_no_dv", dv_cnt, 0);
    chk("mid_no_meas", mv_cnt, 0);
    chk("mid_idle", busy, 0);
    measure(5, t);
    wait_frame("mid", 8'h00, 8'h00, 8'h05, 8'h02);

    chk("dv_while_active", dv_active_total, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
